// File: rtl/systolic_ctrl_pkg.sv
// Shared types and timing constants for the PE-array tile sequencer.
package systolic_ctrl_pkg;

  // Sequencer states, in the order a tile walks through them.
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CLEAR       = 3'd1,
    S_LOAD_W      = 3'd2,
    S_W_SETTLE    = 3'd3,
    S_STREAM_WAIT = 3'd4,
    S_STREAM      = 3'd5,
    S_DRAIN       = 3'd6,
    S_DONE        = 3'd7
  } ctrl_state_e;

  // Default array geometry and reduction limit.
  localparam int N_DEFAULT     = 14;
  localparam int K_MAX_DEFAULT = 1024;

  // Phase lengths of the default 14x14 array.
  localparam int W_BEATS    = N_DEFAULT;
  localparam int SETTLE_CYC = N_DEFAULT;
  localparam int DRAIN_CYC  = 2 * N_DEFAULT - 2;

  // Weight rows streamed into column 0, one per accepted beat.
  function automatic int w_beats(input int n);
    return n;
  endfunction

  // Cycles for load_weight to ripple from column 0 to the last column.
  function automatic int settle_cycles(input int n);
    return n;
  endfunction

  // Cycles to flush the diagonal skew after the last activation vector.
  function automatic int drain_cycles(input int n);
    return 2 * n - 2;
  endfunction

  // The shared phase counter must hold both k_len-1 and the longest fixed phase.
  function automatic int ctr_width(input int kw, input int n);
    int phase_w;
    phase_w = $clog2(2 * n);
    return (kw > phase_w) ? kw : phase_w;
  endfunction

endpackage

// File: rtl/systolic_ctrl_phase_counter.sv
// Loadable down-counter that times every sequencer phase.
// The owner loads (length-1) on phase entry and watches zero.
module phase_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the weight-stationary INT8 PE array: clear, load
// weights, settle, stream K activation vectors, drain the skew, done.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int K_MAX = K_MAX_DEFAULT,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          abort,
  input  logic          wgt_valid,
  output logic          wgt_ready,
  input  logic          act_valid,
  output logic          act_rd_en,
  output logic          pe_clr,
  output logic          pe_load_weight,
  output logic          pe_en,
  output logic          busy,
  output logic          done,
  output logic          err_zero_k,
  output logic          err_underflow
);

  localparam int CW = ctr_width(KW, N);

  // Counter reload values: every phase counts (length-1) down to zero.
  localparam logic [CW-1:0] LOAD_LAST   = CW'(w_beats(N) - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(settle_cycles(N) - 1);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(drain_cycles(N) - 1);

  ctrl_state_e   state;
  ctrl_state_e   next_state;
  logic [KW-1:0] k_len_q;
  logic [CW-1:0] k_last;
  logic          k_bad;
  logic          accept;
  logic          ctr_load;
  logic          ctr_en;
  logic [CW-1:0] ctr_val;
  logic          ctr_zero;

  // A zero or oversized reduction length skips the array entirely.
  assign k_bad  = (k_len == '0) || (k_len > KW'(K_MAX));
  assign accept = (state == S_IDLE) && start && !abort;
  assign k_last = CW'(k_len_q) - CW'(1);

  phase_counter #(
    .W (CW)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_val),
    .en       (ctr_en),
    .zero     (ctr_zero)
  );

  // Next-state and counter control; abort overrides every state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    next_state = state;
    ctr_load   = 1'b0;
    ctr_val    = '0;
    ctr_en     = 1'b0;
    if (abort) begin
      next_state = S_IDLE;
      ctr_load   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            next_state = k_bad ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: begin
          next_state = S_LOAD_W;
          ctr_load   = 1'b1;
          ctr_val    = LOAD_LAST;
        end
        S_LOAD_W: begin
          // Only accepted beats advance the count; a missing beat stalls.
          ctr_en = wgt_valid;
          if (wgt_valid && ctr_zero) begin
            next_state = S_W_SETTLE;
            ctr_load   = 1'b1;
            ctr_val    = SETTLE_LAST;
          end
        end
        S_W_SETTLE: begin
          ctr_en = 1'b1;
          if (ctr_zero) begin
            // Go straight to STREAM when activations are already waiting.
            next_state = act_valid ? S_STREAM : S_STREAM_WAIT;
            ctr_load   = 1'b1;
            ctr_val    = k_last;
          end
        end
        S_STREAM_WAIT: begin
          if (act_valid) begin
            next_state = S_STREAM;
            ctr_load   = 1'b1;
            ctr_val    = k_last;
          end
        end
        S_STREAM: begin
          // The activation pipeline is free-running, so this never stalls.
          ctr_en = 1'b1;
          if (ctr_zero) begin
            next_state = S_DRAIN;
            ctr_load   = 1'b1;
            ctr_val    = DRAIN_LAST;
          end
        end
        S_DRAIN: begin
          ctr_en = 1'b1;
          if (ctr_zero) begin
            next_state = S_DONE;
          end
        end
        S_DONE: begin
          next_state = S_IDLE;
        end
        default: begin
          next_state = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the reduction length of the accepted tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_len_q <= '0;
    end else if (accept) begin
      k_len_q <= k_len;
    end
  end

  // Sticky error flags: cleared by an accepted start, kept through abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_zero_k    <= 1'b0;
      err_underflow <= 1'b0;
    end else if (accept) begin
      err_zero_k    <= k_bad;
      err_underflow <= 1'b0;
    end else if (act_rd_en && !act_valid) begin
      err_underflow <= 1'b1;
    end
  end

  // PE control lines decode straight from state so the phases are exclusive.
  assign busy           = (state != S_IDLE);
  assign pe_clr         = (state == S_CLEAR);
  assign wgt_ready      = (state == S_LOAD_W);
  assign pe_load_weight = wgt_ready && wgt_valid;
  assign act_rd_en      = (state == S_STREAM);
  assign pe_en          = (state == S_STREAM) || (state == S_DRAIN);
  assign done           = (state == S_DONE);

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: cycle-accurate schedule checks of a
// tile against hand-derived offsets from the start cycle T0.
module tb_systolic_ctrl;

  localparam int KW = 11;

  // Indices into the per-signal activity log.
  localparam int I_CLR  = 0;
  localparam int I_LD   = 1;
  localparam int I_RD   = 2;
  localparam int I_EN   = 3;
  localparam int I_DONE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          wgt_valid;
  logic          wgt_ready;
  logic          act_valid;
  logic          act_rd_en;
  logic          pe_clr;
  logic          pe_load_weight;
  logic          pe_en;
  logic          busy;
  logic          done;
  logic          err_zero_k;
  logic          err_underflow;

  int cyc      = 0;
  int t0       = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_viol   = 0;
  int cnt     [5];
  int first_c [5];
  int last_c  [5];

  systolic_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_len          (k_len),
    .abort          (abort),
    .wgt_valid      (wgt_valid),
    .wgt_ready      (wgt_ready),
    .act_valid      (act_valid),
    .act_rd_en      (act_rd_en),
    .pe_clr         (pe_clr),
    .pe_load_weight (pe_load_weight),
    .pe_en          (pe_en),
    .busy           (busy),
    .done           (done),
    .err_zero_k     (err_zero_k),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: counts pulses and records first/last cycle per line.
  always @(negedge clk) begin
    logic [4:0] s;
    s = {done, pe_en, act_rd_en, pe_load_weight, pe_clr};
    for (int i = 0; i < 5; i++) begin
      if (s[i]) begin
        cnt[i]++;
        if (first_c[i] < 0) first_c[i] = cyc - t0;
        last_c[i] = cyc - t0;
      end
    end
    if ((pe_en && pe_load_weight) || (pe_clr && (pe_en || pe_load_weight)))
      n_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({wgt_ready, pe_clr, pe_load_weight, pe_en, act_rd_en,
                 busy, done, err_zero_k, err_underflow});
  endfunction

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 5; i++) begin
      cnt[i]     = 0;
      first_c[i] = -1;
      last_c[i]  = -1;
    end
    n_viol = 0;
  endtask

  // Present start for one cycle (T0); returns early in T1.
  task automatic start_tile(input int k);
    tick();
    t0 = cyc;
    clear_log();
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  // Run until the done pulse has been seen, bounded by a cycle budget.
  task automatic run_until_done(input string tag, input int budget);
    int n;
    n = 0;
    while (cnt[I_DONE] == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, int'(cnt[I_DONE] > 0), 1);
  endtask

  initial begin
    clear_log();
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    abort     = 1'b0;
    wgt_valid = 1'b1;
    act_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    tick();
    rst = 1'b0;

    // Nominal tile, k=16: STREAM T30-T45, DRAIN T46-T71, done T72.
    start_tile(16);
    run_until_done("nom", 200);
    check("nom_clr_cnt",   cnt[I_CLR],     1);
    check("nom_clr_at",    first_c[I_CLR], 1);
    check("nom_ld_cnt",    cnt[I_LD],      14);
    check("nom_ld_first",  first_c[I_LD],  2);
    check("nom_ld_last",   last_c[I_LD],   15);
    check("nom_rd_cnt",    cnt[I_RD],      16);
    check("nom_rd_first",  first_c[I_RD],  30);
    check("nom_rd_last",   last_c[I_RD],   45);
    check("nom_en_cnt",    cnt[I_EN],      42);
    check("nom_en_first",  first_c[I_EN],  30);
    check("nom_en_last",   last_c[I_EN],   71);
    check("nom_done_at",   first_c[I_DONE], 72);
    check("nom_excl",      n_viol,         0);
    @(negedge clk);
    check("nom_busy_t73",  int'(busy),     0);
    check("nom_done_cnt",  cnt[I_DONE],    1);

    // Weight stall: beats 1-5 at T2-T6, gap T7-T9, rest T10-T18; done +3.
    start_tile(16);
    repeat (6) tick();
    wgt_valid = 1'b0;
    repeat (3) tick();
    wgt_valid = 1'b1;
    run_until_done("stall", 200);
    check("stall_ld_cnt",  cnt[I_LD],       14);
    check("stall_ld_last", last_c[I_LD],    18);
    check("stall_rd_first", first_c[I_RD],  33);
    check("stall_done_at", first_c[I_DONE], 75);
    check("stall_excl",    n_viol,          0);

    // k_len=0: straight to DONE at T1, nothing driven into the array.
    start_tile(0);
    run_until_done("k0", 20);
    check("k0_done_at",    first_c[I_DONE], 1);
    check("k0_clr_cnt",    cnt[I_CLR],      0);
    check("k0_ld_cnt",     cnt[I_LD],       0);
    check("k0_en_cnt",     cnt[I_EN],       0);
    @(negedge clk);
    check("k0_err",        int'(err_zero_k), 1);

    // k_len above K_MAX behaves the same way.
    start_tile(1025);
    run_until_done("kbig", 20);
    check("kbig_done_at",  first_c[I_DONE], 1);
    check("kbig_en_cnt",   cnt[I_EN],       0);
    @(negedge clk);
    check("kbig_err",      int'(err_zero_k), 1);

    // k_len=1: one read at T30, DRAIN T31-T56, done T57; error cleared.
    start_tile(1);
    @(negedge clk);
    check("k1_err_clear",  int'(err_zero_k), 0);
    run_until_done("k1", 200);
    check("k1_rd_cnt",     cnt[I_RD],       1);
    check("k1_rd_at",      first_c[I_RD],   30);
    check("k1_en_cnt",     cnt[I_EN],       27);
    check("k1_done_at",    first_c[I_DONE], 57);

    // Underflow at T35: flag set and sticky, schedule unchanged.
    start_tile(16);
    repeat (34) tick();
    act_valid = 1'b0;
    tick();
    act_valid = 1'b1;
    run_until_done("uf", 200);
    check("uf_rd_cnt",     cnt[I_RD],       16);
    check("uf_done_at",    first_c[I_DONE], 72);
    @(negedge clk);
    check("uf_flag",       int'(err_underflow), 1);
    start_tile(1);
    @(negedge clk);
    check("uf_flag_clear", int'(err_underflow), 0);
    run_until_done("uf_next", 200);
    check("uf_next_done_at", first_c[I_DONE], 57);

    // Abort during LOAD_W beat 7 (T8): idle at T9, no done afterwards.
    start_tile(16);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("ab_outputs",    outs(), 0);
    repeat (80) tick();
    check("ab_no_done",    cnt[I_DONE], 0);
    check("ab_ld_cnt",     cnt[I_LD],   7);
    start_tile(2);
    run_until_done("ab_next", 200);
    check("ab_next_ld_cnt",  cnt[I_LD],       14);
    check("ab_next_done_at", first_c[I_DONE], 58);

    // Reset during STREAM after an underflow at T33: everything returns to 0.
    start_tile(16);
    repeat (32) tick();
    act_valid = 1'b0;
    tick();
    act_valid = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_uf_before", int'(err_underflow), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_outputs",   outs(), 0);
    repeat (70) tick();
    check("rst_no_done",   cnt[I_DONE], 0);

    // Start pulses in W_SETTLE (T20) and DRAIN (T60) are ignored.
    start_tile(16);
    repeat (19) tick();
    start = 1'b1;
    k_len = KW'(5);
    tick();
    start = 1'b0;
    repeat (39) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k_len = KW'(16);
    run_until_done("sb", 200);
    check("sb_done_at",    first_c[I_DONE], 72);
    check("sb_rd_cnt",     cnt[I_RD],       16);
    check("sb_en_cnt",     cnt[I_EN],       42);
    repeat (5) tick();
    check("sb_done_cnt",   cnt[I_DONE],     1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
